// File: rtl/hex_entry_buffer.sv
// Hex digit entry buffer: collects nibbles from the switch edge detector into a
// right-aligned word, supports delete/clear edits and commits words downstream.
module hex_entry_buffer #(
    parameter int DATA_W = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [3:0]                           hex,
    input  logic                                 pulse,
    input  logic                                 del,
    input  logic                                 clr,
    input  logic                                 commit,
    input  logic                                 out_ready,
    output logic [DATA_W-1:0]                    out_data,
    output logic                                 out_valid,
    output logic [DATA_W-1:0]                    buf_data,
    output logic [$clog2((DATA_W/4)+1)-1:0]      digit_cnt,
    output logic                                 ovf
);

    localparam int DIGITS = DATA_W / 4;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [DATA_W-1:0] f_shift_in(input logic [DATA_W-1:0] word,
                                                      input logic [3:0] nib);
        return {word[DATA_W-5:0], nib};
    endfunction

    function automatic logic [DATA_W-1:0] f_drop_newest(input logic [DATA_W-1:0] word);
        return {4'h0, word[DATA_W-1:4]};
    endfunction

    logic                 r_pulse_d;
    logic [DATA_W-1:0]    r_buf;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf;
    logic [DATA_W-1:0]    r_out_data;
    logic                 r_out_valid;

    logic                 w_nib;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_xfer;
    logic                 w_commit_ok;

    // hex is registered upstream, so the digit is sampled one cycle after its pulse
    assign w_nib       = r_pulse_d;
    assign w_empty     = (r_cnt == '0);
    assign w_full      = (r_cnt == CNT_FULL);
    assign w_xfer      = r_out_valid && out_ready;
    assign w_commit_ok = commit && !clr && !w_empty && (!r_out_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulse_d <= 1'b0;
        end else begin
            r_pulse_d <= pulse;
        end
    end

    // Edit path: exactly one action per edge, clr > commit > del > nib.
    // A refused commit still wins the edge and discards lower-priority events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (commit) begin
            if (w_commit_ok) begin
                r_buf <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end
        end else if (del) begin
            if (!w_empty) begin
                r_buf <= f_drop_newest(r_buf);
                r_cnt <= r_cnt - CNT_ONE;
            end
        end else if (w_nib) begin
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_buf <= f_shift_in(r_buf, hex);
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // Output register: a same-edge commit refills the slot being drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_commit_ok) begin
            r_out_data  <= r_buf;
            r_out_valid <= 1'b1;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign buf_data  = r_buf;
    assign digit_cnt = r_cnt;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_hex_entry_buffer.sv
// Directed bench for hex_entry_buffer: entry latency, overflow, edits,
// handshake stall and same-cycle event priority.
module tb_hex_entry_buffer;

    logic        clk;
    logic        rst;
    logic [3:0]  hex;
    logic        pulse;
    logic        del;
    logic        clr;
    logic        commit;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic [31:0] buf_data;
    logic [3:0]  digit_cnt;
    logic        ovf;

    int total;
    int bad;

    hex_entry_buffer #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .hex       (hex),
        .pulse     (pulse),
        .del       (del),
        .clr       (clr),
        .commit    (commit),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .buf_data  (buf_data),
        .digit_cnt (digit_cnt),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // pulse in one cycle, digit code presented the next
    task automatic enter(input logic [3:0] d);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        hex   = d;
        tick();
    endtask

    // back-to-back pulses entering digits 1..8
    task automatic fill8();
        pulse = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            hex   = 4'(i);
            pulse = (i < 8);
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; hex = 4'h0; pulse = 1'b0; del = 1'b0; clr = 1'b0;
        commit = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_buf",   buf_data, 32'h0);
        chk("rst_cnt",   32'(digit_cnt), 32'd0);
        chk("rst_ovf",   32'(ovf), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_odata", out_data, 32'h0);
        rst = 1'b0;
        tick();

        // entry with two-edge latency
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        hex   = 4'h1;
        chk("lat_cnt_early", 32'(digit_cnt), 32'd0);
        tick();
        chk("lat_buf_1", buf_data, 32'h1);
        enter(4'h2);
        enter(4'h3);
        chk("entry_buf", buf_data, 32'h123);
        chk("entry_cnt", 32'(digit_cnt), 32'd3);

        // async reset with a pending pulse_d
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        hex   = 4'h7;
        #1 rst = 1'b1;
        #1;
        chk("arst_buf_now", buf_data, 32'h0);
        chk("arst_cnt_now", 32'(digit_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_no_capture", 32'(digit_cnt), 32'd0);

        // fill, overflow, delete, clear
        fill8();
        chk("full_buf", buf_data, 32'h12345678);
        chk("full_cnt", 32'(digit_cnt), 32'd8);
        chk("full_ovf0", 32'(ovf), 32'd0);
        enter(4'hF);
        chk("ovf_buf", buf_data, 32'h12345678);
        chk("ovf_cnt", 32'(digit_cnt), 32'd8);
        chk("ovf_set", 32'(ovf), 32'd1);
        del = 1'b1;
        tick();
        del = 1'b0;
        chk("del_buf", buf_data, 32'h01234567);
        chk("del_cnt", 32'(digit_cnt), 32'd7);
        chk("del_ovf", 32'(ovf), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_buf", buf_data, 32'h0);
        chk("clr_cnt", 32'(digit_cnt), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);

        // handshake stall
        enter(4'hA);
        enter(4'hB);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("cm_valid", 32'(out_valid), 32'd1);
        chk("cm_data",  out_data, 32'hAB);
        chk("cm_buf",   buf_data, 32'h0);
        chk("cm_cnt",   32'(digit_cnt), 32'd0);
        enter(4'hC);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("stall_data",  out_data, 32'hAB);
        chk("stall_buf",   buf_data, 32'hC);
        chk("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("xfer_valid", 32'(out_valid), 32'd0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("cm2_data",  out_data, 32'hC);
        chk("cm2_valid", 32'(out_valid), 32'd1);

        // commit on the transfer edge keeps out_valid high
        enter(4'hD);
        enter(4'hE);
        out_ready = 1'b1;
        commit    = 1'b1;
        tick();
        commit    = 1'b0;
        out_ready = 1'b0;
        chk("refill_valid", 32'(out_valid), 32'd1);
        chk("refill_data",  out_data, 32'hDE);

        // clr beats commit
        enter(4'h5);
        clr    = 1'b1;
        commit = 1'b1;
        tick();
        clr    = 1'b0;
        commit = 1'b0;
        chk("clrcm_buf",   buf_data, 32'h0);
        chk("clrcm_valid", 32'(out_valid), 32'd1);
        chk("clrcm_data",  out_data, 32'hDE);

        // empty commit is ignored while the pending word drains
        out_ready = 1'b1;
        commit    = 1'b1;
        tick();
        commit    = 1'b0;
        out_ready = 1'b0;
        chk("empty_cm_valid", 32'(out_valid), 32'd0);
        chk("empty_cm_data",  out_data, 32'hDE);

        // del beats nib; the nibble is lost, not deferred
        enter(4'h1);
        enter(4'h2);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        hex   = 4'h9;
        del   = 1'b1;
        tick();
        del   = 1'b0;
        chk("prio_buf", buf_data, 32'h1);
        chk("prio_cnt", 32'(digit_cnt), 32'd1);
        tick();
        chk("prio_lost", buf_data, 32'h1);

        // accepted commit clears ovf
        clr = 1'b1;
        tick();
        clr = 1'b0;
        fill8();
        enter(4'h0);
        chk("ovf2_set", 32'(ovf), 32'd1);
        out_ready = 1'b1;
        commit    = 1'b1;
        tick();
        commit    = 1'b0;
        chk("ovf2_clr",  32'(ovf), 32'd0);
        chk("ovf2_data", out_data, 32'h12345678);

        // del on empty buffer
        del = 1'b1;
        tick();
        del = 1'b0;
        chk("del_empty_cnt", 32'(digit_cnt), 32'd0);
        chk("del_empty_buf", buf_data, 32'h0);
        tick();
        chk("final_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_entry_buffer.md
# hex_entry_buffer

Assembles hexadecimal digits from the switch-change detector into a DATA_W-bit word. Each switch-change event appends one nibble. Delete, clear and commit strobes edit the word and release it downstream. The block sits between the switch edge detector (hex code + one-cycle pulse) and the debug/console consumer. The consumer takes committed words over a valid/ready handshake and displays the live buffer on the seven-segment driver.

## Interface

Parameters:
- DATA_W, default 32: word width; must be a multiple of 4. DIGITS = DATA_W/4 (derived, 8 by default).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- hex  in  4  digit code from the edge detector; registered upstream and valid the cycle after pulse
- pulse  in  1  one-cycle strobe; a switch changed
- del  in  1  one-cycle strobe; remove most recently entered digit
- clr  in  1  one-cycle strobe; empty buffer and clear overflow
- commit  in  1  one-cycle strobe; hand buffer to output
- out_ready  in  1  consumer accepts out_data
- out_data  out  DATA_W  committed word, stable while out_valid=1
- out_valid  out  1  out_data holds an unaccepted word
- buf_data  out  DATA_W  live buffer, right-aligned, newest digit in bits [3:0]
- digit_cnt  out  $clog2(DIGITS+1)  digits currently in buffer, 0..DIGITS
- ovf  out  1  sticky; a digit was dropped because buffer was full

## Operation

- pulse is delayed one register stage (pulse_d). A nibble event ("nib") occurs in a cycle where pulse_d=1; hex is sampled in that cycle, not in the pulse cycle.
- One action per edge, priority clr > commit > del > nib. Lower-priority events in the same cycle are discarded, not deferred.
- clr: buf_data=0, digit_cnt=0, ovf=0. out_valid/out_data untouched.
- commit, accepted when digit_cnt≠0 AND (out_valid=0 OR out_ready=1):
  - out_data<=buf_data, out_valid<=1
  - buf_data<=0, digit_cnt<=0, ovf<=0
- commit, ignored when digit_cnt=0, or when out_valid=1 and out_ready=0. No state changes.
- del: if digit_cnt>0, buf_data<=buf_data>>4 (zero fill) and digit_cnt--. Otherwise no-op. ovf unchanged.
- nib with digit_cnt<DIGITS: buf_data<={buf_data[DATA_W-5:0],hex}, digit_cnt++.
- nib with digit_cnt=DIGITS: nibble dropped, buffer unchanged, ovf<=1.
- Output handshake:
  - Transfer occurs on an edge with out_valid=1 and out_ready=1.
  - out_valid clears on that edge unless a commit is accepted on the same edge; then out_valid stays 1 with the new data.
  - out_data never changes while out_valid=1 and out_ready=0.
- out_ready while out_valid=0 has no effect.

## Timing

- Reset (async, immediate): buf_data=0, digit_cnt=0, ovf=0, out_valid=0, out_data=0, pulse_d=0. Reset mid-entry or mid-handshake discards everything; a pulse seen in the cycle before reset deassertion is lost.
- Digit latency: pulse high in cycle T, hex valid in T+1, buf_data/digit_cnt update at the edge ending T+1 (two edges after the pulse edge).
- Back-to-back pulses in consecutive cycles: each digit is taken, one digit per cycle.
- del/clr/commit act at the edge ending the strobe cycle. The result is visible the next cycle.
- commit -> out_valid high one edge later. Minimum out_valid duration is one cycle (out_ready held high).
- Overflow: ovf rises at the edge that drops the nibble. It falls only on clr, accepted commit, or rst.
- Stall: while out_valid=1 and out_ready=0, entry/del/clr continue normally and commit is ignored.

## Test plan

- Reset: assert rst during random activity -> all outputs 0 in the same cycle, no digit captured from a pulse_d pending at reset.
- Entry: pulses with hex=1,2,3 (hex changed the cycle after each pulse) -> buf_data=0x00000123, digit_cnt=3. Each update lands two edges after its pulse.
- Full/overflow: enter 1..8, then F -> buf_data=0x12345678, digit_cnt=8, ovf=1. Then del -> 0x01234567, digit_cnt=7, ovf=1. Then clr -> 0, 0, ovf=0.
- Handshake stall: enter 0xAB, commit with out_ready=0 -> out_valid=1, out_data=0xAB, buf_data=0. Enter 0xC, commit -> ignored, buf_data=0xC. Raise out_ready -> out_valid=0 next edge. Commit -> out_data=0xC.
- Simultaneous events: commit with out_valid=1 and out_ready=1 same edge -> out_valid stays 1 with new word. clr+commit same cycle -> buffer cleared, out_valid unchanged. commit with digit_cnt=0 -> ignored.
- Priority: nib and del in same cycle at digit_cnt=2 (0x12) -> del wins, buf_data=0x1, the nibble is lost.
